// File: rtl/ils_instr_gen.sv
// Seeded-LFSR instruction source (RV32I I-ALU / LB/LBU / SB) with valid/ready stall handshake.
// Optional ILS_ADDR_LIMIT_EN: restricts load/store to x0-based word offsets 0..60.
module ils_instr_gen #(
  parameter logic [31:0] SEED       = 32'h0000_0339,
  parameter int unsigned NOP_CYCLES = 3,
  parameter logic [15:0] MAX_INSTRS = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [1:0]  instr_kind,
  output logic [15:0] instr_count,
  output logic        done
);

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic [1:0] {
    ST_NOP,
    ST_GEN,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] lfsr, lfsr_nxt;
  logic [31:0] nop_cnt, nop_cnt_nxt;
  logic [15:0] count, count_nxt;

  logic [11:0] imm, alu_imm, mem_imm;
  logic [4:0]  rs1, rd, rs2, mem_rs1;
  logic [2:0]  funct3, funct3_l;
  logic [1:0]  choice;
  logic [31:0] gen_word;
  logic [31:0] lfsr_step;

  assign imm      = lfsr[11:0];
  assign rs1      = lfsr[16:12];
  assign rd       = lfsr[21:17];
  assign funct3   = lfsr[24:22];
  assign choice   = lfsr[26:25];
  assign funct3_l = {lfsr[27], 2'b00};
  assign rs2      = lfsr[31:27];

  assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);

  // Shift immediates keep only legal shamt bits (plus the SRAI select bit for funct3 5).
  always_comb begin
    alu_imm = imm;
    if (funct3 == 3'd5)
      alu_imm = imm & 12'h41F;
    else if (funct3 == 3'd1)
      alu_imm = imm & 12'h01F;
  end

`ifdef ILS_ADDR_LIMIT_EN
  assign mem_imm = imm & 12'h03C;
  assign mem_rs1 = '0;
`else
  assign mem_imm = imm;
  assign mem_rs1 = rs1;
`endif

  always_comb begin
    gen_word = NOP_WORD;
    if (choice[1])
      gen_word = {alu_imm, rs1, funct3, rd, 7'b0010011};
    else if (choice[0])
      gen_word = {mem_imm[11:5], rs2, mem_rs1, 3'b000, mem_imm[4:0], 7'b0100011};
    else
      gen_word = {mem_imm, mem_rs1, funct3_l, rd, 7'b0000011};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_NOP;
      lfsr    <= SEED_EFF;
      nop_cnt <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      lfsr    <= lfsr_nxt;
      nop_cnt <= nop_cnt_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lfsr_nxt    = lfsr;
    nop_cnt_nxt = nop_cnt;
    count_nxt   = count;
    instr_valid = 1'b0;
    instr       = NOP_WORD;
    instr_kind  = 2'd0;
    done        = 1'b0;
    case (state)
      ST_NOP: begin
        if (nop_cnt + 32'd1 >= NOP_CYCLES) begin
          state_nxt   = ST_GEN;
          nop_cnt_nxt = '0;
        end else begin
          nop_cnt_nxt = nop_cnt + 32'd1;
        end
      end
      ST_GEN: begin
        instr_valid = en;
        if (en) begin
          instr      = gen_word;
          instr_kind = choice;
          if (instr_ready) begin
            lfsr_nxt  = lfsr_step;
            count_nxt = (count == 16'hFFFF) ? count : count + 16'd1;
            if (MAX_INSTRS != 16'd0 && count + 16'd1 == MAX_INSTRS)
              state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = ST_NOP;
      end
    endcase
  end

  assign instr_count = count;

endmodule

// File: tb/tb_ils_instr_gen.sv
// Directed bench for ils_instr_gen: several seeds, backpressure, enable gaps, mid-run reset, MAX_INSTRS stop.
module tb_ils_instr_gen;

  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b1, ready = 1'b0;
  logic reset6 = 1'b1, en6 = 1'b1, ready6 = 1'b0;

  logic        valid_w [1:6];
  logic [31:0] instr_w [1:6];
  logic [1:0]  kind_w  [1:6];
  logic [15:0] count_w [1:6];
  logic        done_w  [1:6];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ils_instr_gen #(.SEED(32'h0600_0005)) u1 (.clk(clk), .reset(reset), .en(en), .instr_ready(ready),
    .instr_valid(valid_w[1]), .instr(instr_w[1]), .instr_kind(kind_w[1]), .instr_count(count_w[1]), .done(done_w[1]));
  ils_instr_gen #(.SEED(32'h0740_0FFF)) u2 (.clk(clk), .reset(reset), .en(en), .instr_ready(ready),
    .instr_valid(valid_w[2]), .instr(instr_w[2]), .instr_kind(kind_w[2]), .instr_count(count_w[2]), .done(done_w[2]));
  ils_instr_gen #(.SEED(32'h0640_0FFF)) u3 (.clk(clk), .reset(reset), .en(en), .instr_ready(ready),
    .instr_valid(valid_w[3]), .instr(instr_w[3]), .instr_kind(kind_w[3]), .instr_count(count_w[3]), .done(done_w[3]));
  ils_instr_gen #(.SEED(32'h0A00_0000)) u4 (.clk(clk), .reset(reset), .en(en), .instr_ready(ready),
    .instr_valid(valid_w[4]), .instr(instr_w[4]), .instr_kind(kind_w[4]), .instr_count(count_w[4]), .done(done_w[4]));
  ils_instr_gen #(.SEED(32'h0000_0000)) u5 (.clk(clk), .reset(reset), .en(en), .instr_ready(ready),
    .instr_valid(valid_w[5]), .instr(instr_w[5]), .instr_kind(kind_w[5]), .instr_count(count_w[5]), .done(done_w[5]));
  ils_instr_gen #(.SEED(32'h0600_0005), .MAX_INSTRS(16'd4)) u6 (.clk(clk), .reset(reset6), .en(en6),
    .instr_ready(ready6), .instr_valid(valid_w[6]), .instr(instr_w[6]), .instr_kind(kind_w[6]),
    .instr_count(count_w[6]), .done(done_w[6]));

  // Reference model: Galois LFSR step and field-wise encoder.
  function automatic logic [31:0] m_step(input logic [31:0] r);
    logic [31:0] s;
    s = r >> 1;
    if (r[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] r);
    logic [11:0] im;
    logic [2:0]  f3;
    im = r[11:0];
    f3 = r[24:22];
    if (r[26]) begin
      if (f3 == 3'd5) im = im & 12'h41F;
      if (f3 == 3'd1) im = im & 12'h01F;
      return {im, r[16:12], f3, r[21:17], 7'h13};
    end else if (r[25]) begin
      return {im[11:5], r[31:27], r[16:12], 3'b000, im[4:0], 7'h23};
    end
    return {im, r[16:12], r[27], 2'b00, r[21:17], 7'h03};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset6 = 1'b1; en = 1'b1; ready = 1'b0;
    tick(); tick();
    for (int k = 1; k <= 6; k++) begin
      checks++; if (valid_w[k] !== 1'b0) begin errors++; $display("FAIL reset_valid u%0d: got %b want 0", k, valid_w[k]); end
      checks++; if (instr_w[k] !== 32'h13) begin errors++; $display("FAIL reset_instr u%0d: got %h want 00000013", k, instr_w[k]); end
      checks++; if (kind_w[k] !== 2'd0) begin errors++; $display("FAIL reset_kind u%0d: got %0d want 0", k, kind_w[k]); end
      checks++; if (count_w[k] !== 16'd0) begin errors++; $display("FAIL reset_count u%0d: got %0d want 0", k, count_w[k]); end
      checks++; if (done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done u%0d: got %b want 0", k, done_w[k]); end
    end
  endtask

  task automatic check_nop_window(input string tag);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (valid_w[1] !== 1'b0 || instr_w[1] !== 32'h13)
        begin errors++; $display("FAIL %s_nop%0d: got v=%b %h want v=0 00000013", tag, n, valid_w[1], instr_w[1]); end
      tick();
    end
  endtask

  task automatic test_first_instr();
    #1;
    checks++; if (valid_w[1] !== 1'b1 || instr_w[1] !== 32'h0050_0013 || kind_w[1] !== 2'd3)
      begin errors++; $display("FAIL first_addi: got v=%b %h k=%0d want v=1 00500013 k=3", valid_w[1], instr_w[1], kind_w[1]); end
    checks++; if (instr_w[2] !== 32'h41F0_5013 || kind_w[2] !== 2'd3)
      begin errors++; $display("FAIL first_srai_mask: got %h k=%0d want 41f05013 k=3", instr_w[2], kind_w[2]); end
    checks++; if (instr_w[3] !== 32'h01F0_1013 || kind_w[3] !== 2'd3)
      begin errors++; $display("FAIL first_slli_mask: got %h k=%0d want 01f01013 k=3", instr_w[3], kind_w[3]); end
    checks++; if (instr_w[4] !== 32'h0010_0023 || kind_w[4] !== 2'd1)
      begin errors++; $display("FAIL first_sb: got %h k=%0d want 00100023 k=1", instr_w[4], kind_w[4]); end
    checks++; if (instr_w[5] !== 32'h0010_0003 || kind_w[5] !== 2'd0)
      begin errors++; $display("FAIL first_seed0_lb: got %h k=%0d want 00100003 k=0", instr_w[5], kind_w[5]); end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (valid_w[1] !== 1'b1 || instr_w[1] !== 32'h0050_0013 || count_w[1] !== 16'd0)
        begin errors++; $display("FAIL stall%0d: got v=%b %h cnt=%0d want v=1 00500013 cnt=0", n, valid_w[1], instr_w[1], count_w[1]); end
    end
    ready = 1'b1;
    tick();
    checks++; if (count_w[1] !== 16'd1 || instr_w[1] !== 32'h0100_00A3 || kind_w[1] !== 2'd1)
      begin errors++; $display("FAIL release: got cnt=%0d %h k=%0d want cnt=1 010000a3 k=1", count_w[1], instr_w[1], kind_w[1]); end
  endtask

  // Runs u1 against the model with en gaps until the model count reaches 'target' handshakes.
  task automatic run_stream(input string tag, input logic [31:0] r0, input int c0, input int target, input int gap_mod, input int gap_at);
    logic [31:0] r;
    int cnt;
    r = r0; cnt = c0;
    for (int i = 0; i < 60 && cnt < target; i++) begin
      en = (i % gap_mod) != gap_at;
      #1;
      checks++;
      if (en) begin
        if (valid_w[1] !== 1'b1 || instr_w[1] !== m_enc(r) || kind_w[1] !== r[26:25] || count_w[1] !== cnt[15:0])
          begin errors++; $display("FAIL %s_word%0d: got v=%b %h k=%0d cnt=%0d want v=1 %h k=%0d cnt=%0d",
                                   tag, i, valid_w[1], instr_w[1], kind_w[1], count_w[1], m_enc(r), r[26:25], cnt); end
      end else begin
        if (valid_w[1] !== 1'b0 || instr_w[1] !== 32'h13 || count_w[1] !== cnt[15:0])
          begin errors++; $display("FAIL %s_gap%0d: got v=%b %h cnt=%0d want v=0 00000013 cnt=%0d",
                                   tag, i, valid_w[1], instr_w[1], count_w[1], cnt); end
      end
      tick();
      if (en) begin r = m_step(r); cnt++; end
    end
    en = 1'b1;
    #1;
    checks++; if (count_w[1] !== target[15:0])
      begin errors++; $display("FAIL %s_count: got %0d want %0d", tag, count_w[1], target); end
  endtask

  task automatic test_midrun_reset();
    reset = 1'b1;
    tick();
    checks++; if (count_w[1] !== 16'd0 || valid_w[1] !== 1'b0 || instr_w[1] !== 32'h13)
      begin errors++; $display("FAIL midrun_reset: got cnt=%0d v=%b %h want cnt=0 v=0 00000013", count_w[1], valid_w[1], instr_w[1]); end
    reset = 1'b0;
    check_nop_window("replay");
    run_stream("replay", 32'h0600_0005, 0, 9, 3, 1);
  endtask

  task automatic test_max_instrs();
    logic [31:0] r;
    int hs;
    bit seen;
    r = 32'h0600_0005; hs = 0; seen = 1'b0;
    reset6 = 1'b1; tick();
    reset6 = 1'b0; ready6 = 1'b1; en6 = 1'b1;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (done_w[6]) begin seen = 1'b1; break; end
      if (valid_w[6] && ready6) begin
        checks++; if (instr_w[6] !== m_enc(r))
          begin errors++; $display("FAIL max_word%0d: got %h want %h", hs, instr_w[6], m_enc(r)); end
        hs++; r = m_step(r);
      end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL max_timeout: done got 0 want 1 within 30 cycles"); end
    checks++; if (hs !== 4) begin errors++; $display("FAIL max_handshakes: got %0d want 4", hs); end
    for (int n = 0; n < 11; n++) begin
      checks++; if (done_w[6] !== 1'b1 || valid_w[6] !== 1'b0 || instr_w[6] !== 32'h13 || count_w[6] !== 16'd4)
        begin errors++; $display("FAIL max_hold%0d: got d=%b v=%b %h cnt=%0d want d=1 v=0 00000013 cnt=4",
                                 n, done_w[6], valid_w[6], instr_w[6], count_w[6]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    reset = 1'b0;
    check_nop_window("start");
    test_first_instr();
    test_backpressure();
    run_stream("stream", m_step(32'h0600_0005), 1, 7, 4, 2);
    test_midrun_reset();
    test_max_instrs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
